// File: rtl/conv_pool_stage.sv
// 2x2 stride-2 signed max pooling over a FMAP_ROWS x ARRAY_SIZE map, one input row per beat.
// Optional ReLU on pooled lanes when CONV_POOL_RELU_EN is defined.
module conv_pool_stage #(
    parameter int WIDTH      = 32,
    parameter int ARRAY_SIZE = 6,
    parameter int FMAP_ROWS  = 6,
    localparam int OUT_LANES = ARRAY_SIZE / 2,
    localparam int CNT_W     = (FMAP_ROWS > 2) ? $clog2(FMAP_ROWS) : 1,
    localparam int IDX_W     = (FMAP_ROWS / 2 > 1) ? $clog2(FMAP_ROWS / 2) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_clear,
    input  logic                          i_valid,
    input  logic [ARRAY_SIZE*WIDTH-1:0]   i_pixel_bus,
    output logic                          o_valid,
    output logic [OUT_LANES*WIDTH-1:0]    o_pool_bus,
    output logic [IDX_W-1:0]              o_row_idx,
    output logic                          o_frame_done,
    output logic                          o_busy
);

    localparam logic [0:0] S_EVEN = 1'b0;
    localparam logic [0:0] S_ODD  = 1'b1;

    logic [0:0]                    state;
    logic [CNT_W-1:0]              row_cnt;
    logic [ARRAY_SIZE*WIDTH-1:0]   row_buf;
    logic [OUT_LANES*WIDTH-1:0]    pooled;
    logic                          last_row;

    function automatic logic signed [WIDTH-1:0] smax(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        logic signed [WIDTH-1:0] m;
        pooled = '0;
        m      = '0;
        for (int unsigned j = 0; j < OUT_LANES; j++) begin
            m = smax(smax(row_buf[(2*j)*WIDTH +: WIDTH], row_buf[(2*j+1)*WIDTH +: WIDTH]),
                     smax(i_pixel_bus[(2*j)*WIDTH +: WIDTH], i_pixel_bus[(2*j+1)*WIDTH +: WIDTH]));
`ifdef CONV_POOL_RELU_EN
            if (m[WIDTH-1]) begin
                m = '0;
            end
`endif
            pooled[j*WIDTH +: WIDTH] = m;
        end
    end

    assign last_row = (row_cnt == CNT_W'(FMAP_ROWS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            state        <= S_EVEN;
            row_cnt      <= '0;
            row_buf      <= '0;
            o_valid      <= 1'b0;
            o_pool_bus   <= '0;
            o_row_idx    <= '0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_row_idx    <= '0;
            if (i_valid) begin
                if (state == S_EVEN) begin
                    row_buf <= i_pixel_bus;
                    row_cnt <= row_cnt + CNT_W'(1);
                    o_busy  <= 1'b1;
                    state   <= S_ODD;
                end else begin
                    o_pool_bus <= pooled;
                    o_valid    <= 1'b1;
                    o_row_idx  <= IDX_W'(row_cnt >> 1);
                    state      <= S_EVEN;
                    // Odd beat of the last pair closes the frame; counter wraps so the next beat is row 0.
                    if (last_row) begin
                        row_cnt      <= '0;
                        o_frame_done <= 1'b1;
                        o_busy       <= 1'b0;
                    end else begin
                        row_cnt <= row_cnt + CNT_W'(1);
                        o_busy  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_pool_stage.sv
// Scoreboard bench for conv_pool_stage: image-level pooling model, decoupled monitor.
module tb_conv_pool_stage;
    localparam int WIDTH      = 32;
    localparam int ARRAY_SIZE = 6;
    localparam int FMAP_ROWS  = 6;
    localparam int OL         = ARRAY_SIZE / 2;
    localparam int IDX_W      = (FMAP_ROWS / 2 > 1) ? $clog2(FMAP_ROWS / 2) : 1;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        i_clear;
    logic                        i_valid;
    logic [ARRAY_SIZE*WIDTH-1:0] i_pixel_bus;
    logic                        o_valid;
    logic [OL*WIDTH-1:0]         o_pool_bus;
    logic [IDX_W-1:0]            o_row_idx;
    logic                        o_frame_done;
    logic                        o_busy;

    always #5 clk = ~clk;

    conv_pool_stage #(.WIDTH(WIDTH), .ARRAY_SIZE(ARRAY_SIZE), .FMAP_ROWS(FMAP_ROWS)) dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid),
        .i_pixel_bus(i_pixel_bus), .o_valid(o_valid), .o_pool_bus(o_pool_bus),
        .o_row_idx(o_row_idx), .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    typedef struct {
        logic [OL*WIDTH-1:0] bus;
        int                  idx;
        logic                done;
        int                  due;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 0;

    // Reference: the current frame as a 2-D image, rows indexed by position in the frame.
    logic signed [WIDTH-1:0] img [FMAP_ROWS][ARRAY_SIZE];
    int m_cnt       = 0;
    bit m_busy      = 0;
    bit m_busy_next = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [OL*WIDTH-1:0] pool_row(input int p);
        logic [OL*WIDTH-1:0]     r;
        logic signed [WIDTH-1:0] best;
        r = '0;
        for (int j = 0; j < OL; j++) begin
            best = img[2*p][2*j];
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++)
                    if (img[2*p+dr][2*j+dc] > best) best = img[2*p+dr][2*j+dc];
`ifdef CONV_POOL_RELU_EN
            if (best < 0) best = 0;
`endif
            r[j*WIDTH +: WIDTH] = best;
        end
        return r;
    endfunction

    task automatic step(input bit v, input logic [ARRAY_SIZE*WIDTH-1:0] bus,
                        input bit clr, input bit rst);
        exp_t e;
        i_valid     = v;
        i_pixel_bus = bus;
        i_clear     = clr;
        rst_n       = ~rst;
        if (rst || clr) begin
            m_cnt       = 0;
            m_busy_next = 0;
        end else if (v) begin
            for (int k = 0; k < ARRAY_SIZE; k++) img[m_cnt][k] = bus[k*WIDTH +: WIDTH];
            if (m_cnt % 2 == 1) begin
                e.bus  = pool_row(m_cnt / 2);
                e.idx  = m_cnt / 2;
                e.done = (m_cnt == FMAP_ROWS - 1);
                e.due  = cyc + 1;
                sb.push_back(e);
            end
            m_cnt       = (m_cnt + 1) % FMAP_ROWS;
            m_busy_next = (m_cnt != 0);
        end else begin
            m_busy_next = m_busy;
        end
        @(posedge clk);
        #1;
        m_busy = m_busy_next;
    endtask

    function automatic logic [ARRAY_SIZE*WIDTH-1:0] ramp_row(input int r);
        logic [ARRAY_SIZE*WIDTH-1:0] b;
        for (int k = 0; k < ARRAY_SIZE; k++) b[k*WIDTH +: WIDTH] = WIDTH'(10 * r + k);
        return b;
    endfunction

    function automatic logic [ARRAY_SIZE*WIDTH-1:0] rand_row();
        logic [ARRAY_SIZE*WIDTH-1:0] b;
        for (int k = 0; k < ARRAY_SIZE; k++) b[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        return b;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, rand_row(), 0, 0);
    endtask

    // kind 0: ramp 10*r+k, kind 1: random
    task automatic send_frame(input int kind, input int max_gap);
        for (int r = 0; r < FMAP_ROWS; r++) begin
            step(1, (kind == 0) ? ramp_row(r) : rand_row(), 0, 0);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic chk_zero(input string name);
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_pool_bus !== '0 || o_row_idx !== '0 ||
            o_frame_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s got valid=%b bus=%h idx=%0d done=%b busy=%b required all zero",
                     name, o_valid, o_pool_bus, o_row_idx, o_frame_done, o_busy);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                if (o_busy !== m_busy) begin
                    errors++;
                    $display("FAIL busy got=%b exp=%b cyc=%0d", o_busy, m_busy, cyc);
                end
                if (o_valid === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid got bus=%h cyc=%0d", o_pool_bus, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.due != cyc) begin
                            errors++;
                            $display("FAIL latency got cyc=%0d exp=%0d", cyc, e.due);
                        end
                        checks += 3;
                        if (o_pool_bus !== e.bus) begin
                            errors++;
                            $display("FAIL pool_bus got=%h exp=%h", o_pool_bus, e.bus);
                        end
                        if (int'(o_row_idx) != e.idx) begin
                            errors++;
                            $display("FAIL row_idx got=%0d exp=%0d", o_row_idx, e.idx);
                        end
                        if (o_frame_done !== e.done) begin
                            errors++;
                            $display("FAIL frame_done got=%b exp=%b", o_frame_done, e.done);
                        end
                    end
                end else begin
                    checks++;
                    if (o_valid !== 1'b0 || o_frame_done !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_pulse got valid=%b done=%b exp 0 0", o_valid, o_frame_done);
                    end
                    if (sb.size() > 0 && sb[0].due <= cyc) begin
                        e = sb.pop_front();
                        checks++;
                        errors++;
                        $display("FAIL missing_valid got=0 exp=1 due=%0d cyc=%0d", e.due, cyc);
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [ARRAY_SIZE*WIDTH-1:0] b;
        logic signed [WIDTH-1:0]     sv [ARRAY_SIZE];
        step(0, '0, 0, 1);
        mon_en = 1;
        step(0, '0, 0, 1);
        chk_zero("reset_state");

        send_frame(0, 0);
        idle(2);

        // Negative data: row0 all -16, row1 mixed negatives
        sv = '{-1, -32, -5, -2, -100, -7};
        for (int k = 0; k < ARRAY_SIZE; k++) b[k*WIDTH +: WIDTH] = WIDTH'(-16);
        step(1, b, 0, 0);
        for (int k = 0; k < ARRAY_SIZE; k++) b[k*WIDTH +: WIDTH] = sv[k];
        step(1, b, 0, 0);
        for (int r = 2; r < FMAP_ROWS; r++) step(1, rand_row(), 0, 0);
        idle(1);

        send_frame(0, 3);
        send_frame(1, 3);

        // Clear after row 2, then a fresh frame
        for (int r = 0; r < 3; r++) step(1, rand_row(), 0, 0);
        step(0, rand_row(), 1, 0);
        idle(2);
        send_frame(0, 0);

        // Reset coincident with an odd-row beat
        step(1, rand_row(), 0, 0);
        step(1, rand_row(), 0, 1);
        chk_zero("reset_on_odd_beat");
        send_frame(1, 0);

        // Clear coincident with an odd-row beat
        step(1, rand_row(), 0, 0);
        step(1, rand_row(), 1, 0);
        send_frame(1, 1);

        send_frame(1, 0);
        send_frame(1, 0);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, rand_row(),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0);

        idle(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
